// File: rtl/branch_pc_unit_pkg.sv
// Shared definitions for the branch/PC sequencer.
// Contents: command op encodings, CON condition-select codes, sequencer
// state encoding and the positions of the C2 / offset fields in the
// instruction word.
package branch_pc_unit_pkg;

    localparam int IR_WIDTH     = 32;
    localparam int IR_OFF_WIDTH = 19;
    localparam int C2_LO        = 19;
    localparam int C2_HI        = 20;

    typedef enum logic [1:0] {
        OP_INC = 2'b00,
        OP_BR  = 2'b01,
        OP_JR  = 2'b10,
        OP_JAL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        COND_ZR = 2'b00,
        COND_NZ = 2'b01,
        COND_PL = 2'b10,
        COND_MI = 2'b11
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EVAL   = 2'b01,
        ST_SETTLE = 2'b10,
        ST_COMMIT = 2'b11
    } state_e;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Command channel into the PC sequencer.
// Signals:
//   cmd_valid  requester has a command
//   cmd_ready  sequencer can take a command this cycle
//   cmd_op     INC / BR / JR / JAL
//   ir         instruction word (C2 and branch offset fields)
//   ra_value   rA contents for JR / JAL
// Modports: master = requester, slave = sequencer.
interface branch_pc_unit_if
    import branch_pc_unit_pkg::*;
#(
    parameter int PC_WIDTH = 32
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [IR_WIDTH-1:0]  ir;
    logic [PC_WIDTH-1:0]  ra_value;

    modport master (
        output cmd_valid,
        output cmd_op,
        output ir,
        output ra_value,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  ir,
        input  ra_value,
        output cmd_ready
    );

endinterface

// File: rtl/branch_pc_unit_pc_next_calc.sv
// Combinational next-PC selection for the PC sequencer.
// Ports:
//   pc        current program counter
//   op        captured command op
//   off       captured signed branch offset field
//   con       sampled CON bit (only meaningful for BR)
//   ra_value  captured rA operand
//   seq       pc + 1 (also the JAL return address)
//   next_pc   value the PC takes at commit
//   taken     1 when next_pc is not the sequential address
module pc_next_calc
    import branch_pc_unit_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int OFF_WIDTH = IR_OFF_WIDTH
) (
    input  logic [PC_WIDTH-1:0]  pc,
    input  op_e                  op,
    input  logic [OFF_WIDTH-1:0] off,
    input  logic                 con,
    input  logic [PC_WIDTH-1:0]  ra_value,
    output logic [PC_WIDTH-1:0]  seq,
    output logic [PC_WIDTH-1:0]  next_pc,
    output logic                 taken
);

    logic signed [PC_WIDTH-1:0] off_ext;

    assign seq     = pc + PC_WIDTH'(1);
    assign off_ext = $signed({{(PC_WIDTH-OFF_WIDTH){off[OFF_WIDTH-1]}}, off});

    always_comb begin
        next_pc = seq;
        taken   = 1'b0;
        case (op)
            OP_INC: begin
            end
            OP_BR: begin
                if (con) begin
                    // Two's-complement add wraps modulo 2^PC_WIDTH.
                    next_pc = seq + $unsigned(off_ext);
                    taken   = 1'b1;
                end
            end
            OP_JR, OP_JAL: begin
                next_pc = ra_value;
                taken   = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program-counter sequencer behind the CON condition logic.
// Accepts one control-flow command per handshake, runs the CON
// evaluate/settle handshake for branches, then commits the next PC.
// Ports:
//   clk, clr   clock and synchronous active-high reset
//   cmd        command channel (slave side)
//   con_sel    condition select to the CON logic
//   con_in     CON flip-flop load strobe (high only in EVAL)
//   con_out    registered CON bit back from the CON logic
//   pc         architectural program counter
//   link_we    one-cycle R15 write strobe (JAL only)
//   link_data  return address old PC + 1
//   done       one-cycle pulse when the commit is visible
//   taken      valid with done; non-sequential target loaded
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter int                PC_WIDTH  = 32,
    parameter int                OFF_WIDTH = IR_OFF_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                clr,
    branch_pc_unit_if.slave     cmd,
    output logic [1:0]          con_sel,
    output logic                con_in,
    input  logic                con_out,
    output logic [PC_WIDTH-1:0] pc,
    output logic                link_we,
    output logic [PC_WIDTH-1:0] link_data,
    output logic                done,
    output logic                taken
);

    state_e                 state;
    state_e                 state_nxt;
    logic                   accept;

    op_e                    op_p0;
    logic [OFF_WIDTH-1:0]   off_p0;
    logic [PC_WIDTH-1:0]    ra_p0;
    logic                   con_p1;

    logic [PC_WIDTH-1:0]    seq;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   taken_nxt;

    // Upper instruction bits carry nothing this unit needs.
    logic                   unused_ir_hi;
    assign unused_ir_hi = ^cmd.ir[IR_WIDTH-1:C2_HI+1];

    assign cmd.cmd_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        con_in    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd.cmd_op == OP_BR) ? ST_EVAL : ST_COMMIT;
                end
            end
            ST_EVAL: begin
                con_in    = 1'b1;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    pc_next_calc #(
        .PC_WIDTH  (PC_WIDTH),
        .OFF_WIDTH (OFF_WIDTH)
    ) u_calc (
        .pc       (pc),
        .op       (op_p0),
        .off      (off_p0),
        .con      (con_p1),
        .ra_value (ra_p0),
        .seq      (seq),
        .next_pc  (next_pc),
        .taken    (taken_nxt)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            pc        <= RESET_PC;
            con_sel   <= COND_ZR;
            link_we   <= 1'b0;
            link_data <= '0;
            done      <= 1'b0;
            taken     <= 1'b0;
            op_p0     <= OP_INC;
            off_p0    <= '0;
            ra_p0     <= '0;
            con_p1    <= 1'b0;
        end else begin
            done    <= 1'b0;
            link_we <= 1'b0;

            // Stage p0: capture the command at acceptance.
            if (accept) begin
                op_p0  <= op_e'(cmd.cmd_op);
                off_p0 <= cmd.ir[OFF_WIDTH-1:0];
                ra_p0  <= cmd.ra_value;
                // con_sel only moves for branches and then holds.
                if (cmd.cmd_op == OP_BR) begin
                    con_sel <= cmd.ir[C2_HI:C2_LO];
                end
            end

            // Stage p1: CON was loaded at the end of EVAL; take it at end of SETTLE.
            if (state == ST_SETTLE) begin
                con_p1 <= con_out;
            end

            // Stage p2: commit; done/link_we become visible the next cycle.
            if (state == ST_COMMIT) begin
                pc    <= next_pc;
                taken <= taken_nxt;
                done  <= 1'b1;
                if (op_p0 == OP_JAL) begin
                    link_we   <= 1'b1;
                    link_data <= seq;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Testbench for branch_pc_unit: directed command sequence, a bench-side
// CON condition block, a transaction-level model compared every cycle,
// and a table of hand-computed PC/taken values for each commit.
module tb_branch_pc_unit;
    import branch_pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic [1:0]  con_sel;
    logic        con_in;
    logic        con_out;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_data;
    logic        done;
    logic        taken;
    logic [31:0] opnd;

    branch_pc_unit_if #(.PC_WIDTH(32)) bus ();

    branch_pc_unit #(
        .PC_WIDTH  (32),
        .OFF_WIDTH (19),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd       (bus),
        .con_sel   (con_sel),
        .con_in    (con_in),
        .con_out   (con_out),
        .pc        (pc),
        .link_we   (link_we),
        .link_data (link_data),
        .done      (done),
        .taken     (taken)
    );

    always #5 clk = ~clk;

    function automatic logic cond_eval(input logic [1:0] sel, input logic [31:0] v);
        case (sel)
            2'b00:   return (v == 32'd0);
            2'b01:   return (v != 32'd0);
            2'b10:   return ($signed(v) > 0);
            default: return ($signed(v) < 0);
        endcase
    endfunction

    function automatic logic [31:0] mk_ir(input logic [1:0] c2, input logic [18:0] c);
        return {11'd0, c2, c};
    endfunction

    // Environment: CON flip-flop loaded from the selected condition on opnd.
    logic con_reg;
    always @(posedge clk) begin
        if (clr) con_reg <= 1'b0;
        else if (con_in) con_reg <= cond_eval(con_sel, opnd);
    end
    assign con_out = con_reg;

    // Hand-computed PC / taken after each successive commit.
    localparam int NLIT = 16;
    localparam logic [31:0] LIT_PC [NLIT] = '{
        32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0100, 32'h0000_0111,
        32'h0000_0100, 32'h0000_0101, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0010, 32'hFFFC_0011, 32'hFFFC_0017, 32'h0000_0200,
        32'h0000_0800, 32'hDEAD_BEEF, 32'h0000_0004, 32'h0000_0005};
    localparam logic LIT_TAKEN [NLIT] = '{
        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Input snapshot at each rising edge.
    int          cyc = 0;
    logic        s_clr = 1'b0;
    logic        s_valid = 1'b0;
    logic [1:0]  s_op = 2'b00;
    logic [31:0] s_ir = '0;
    logic [31:0] s_ra = '0;
    logic [31:0] s_opnd = '0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        s_clr   <= clr;
        s_valid <= bus.cmd_valid;
        s_op    <= bus.cmd_op;
        s_ir    <= bus.ir;
        s_ra    <= bus.ra_value;
        s_opnd  <= opnd;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Transaction model state.
    logic        started = 1'b0;
    logic        pend = 1'b0;
    int          due = 0;
    int          ncommit = 0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_link = '0;
    logic [1:0]  m_sel = 2'b00;
    logic [31:0] p_pc = '0;
    logic        p_taken = 1'b0;
    logic        p_jal = 1'b0;
    logic [31:0] p_link = '0;

    always @(negedge clk) begin
        logic e_done, e_lw, e_con_in, e_taken;
        int   off;
        e_done   = 1'b0;
        e_lw     = 1'b0;
        e_con_in = 1'b0;
        e_taken  = 1'b0;
        if (s_clr) begin
            started = 1'b1;
            pend    = 1'b0;
            m_pc    = 32'h0;
            m_link  = 32'h0;
            m_sel   = 2'b00;
        end else if (started) begin
            if (pend && cyc == due) begin
                pend    = 1'b0;
                e_done  = 1'b1;
                e_taken = p_taken;
                m_pc    = p_pc;
                if (p_jal) begin
                    e_lw   = 1'b1;
                    m_link = p_link;
                end
            end else if (!pend && s_valid) begin
                pend   = 1'b1;
                p_jal  = (s_op == 2'b11);
                p_link = m_pc + 32'd1;
                if (s_op == 2'b01) begin
                    off = int'(s_ir[18:0]);
                    if (s_ir[18]) off = off - 524288;
                    if (cond_eval(s_ir[20:19], s_opnd)) begin
                        p_pc    = m_pc + 32'd1 + 32'(off);
                        p_taken = 1'b1;
                    end else begin
                        p_pc    = m_pc + 32'd1;
                        p_taken = 1'b0;
                    end
                    m_sel    = s_ir[20:19];
                    e_con_in = 1'b1;
                    due      = cyc + 3;
                end else if (s_op == 2'b00) begin
                    p_pc    = m_pc + 32'd1;
                    p_taken = 1'b0;
                    due     = cyc + 1;
                end else begin
                    p_pc    = s_ra;
                    p_taken = 1'b1;
                    due     = cyc + 1;
                end
            end
        end
        if (started) begin
            chk("pc", pc, m_pc);
            chk("done", 32'(done), 32'(e_done));
            chk("link_we", 32'(link_we), 32'(e_lw));
            chk("link_data", link_data, m_link);
            chk("con_in", 32'(con_in), 32'(e_con_in));
            chk("con_sel", 32'(con_sel), 32'(m_sel));
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(!pend));
            if (e_done || s_clr) chk("taken", 32'(taken), 32'(e_taken));
            if (e_done) begin
                if (ncommit < NLIT) begin
                    chk("lit_pc", pc, LIT_PC[ncommit]);
                    chk("lit_taken", 32'(taken), 32'(LIT_TAKEN[ncommit]));
                    if (ncommit == 12) chk("lit_link", link_data, 32'h0000_0201);
                end else begin
                    chk("extra_commit", 32'(ncommit), 32'(NLIT - 1));
                end
                ncommit++;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] ir, input logic [31:0] ra);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.ir        = ir;
        bus.ra_value  = ra;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_ready) begin
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        $display("FAIL accept_timeout: cmd_ready never seen, want 1");
        $fatal(1, "accept timeout");
    endtask

    task automatic wait_done();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) return;
        end
        $display("FAIL done_timeout: done never seen, want 1");
        $fatal(1, "done timeout");
    endtask

    initial begin
        clr           = 1'b1;
        opnd          = 32'd0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.ir        = 32'd0;
        bus.ra_value  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        clr           = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);

        send(2'b10, 32'd0, 32'hFFFF_FFFF); wait_done();
        send(2'b00, 32'd0, 32'd0);         wait_done();
        send(2'b10, 32'd0, 32'h0000_0100); wait_done();
        opnd = 32'd0;
        send(2'b01, mk_ir(2'b00, 19'h00010), 32'd0); wait_done();
        send(2'b10, 32'd0, 32'h0000_0100); wait_done();
        opnd = 32'd5;
        send(2'b01, mk_ir(2'b00, 19'h00010), 32'd0); wait_done();
        send(2'b10, 32'd0, 32'd0);         wait_done();
        send(2'b01, mk_ir(2'b01, 19'h7FFFF), 32'd0); wait_done();
        send(2'b10, 32'd0, 32'h0000_0010); wait_done();
        opnd = 32'd7;
        send(2'b01, mk_ir(2'b10, 19'h40000), 32'd0); wait_done();
        opnd = 32'h8000_0000;
        send(2'b01, mk_ir(2'b11, 19'h00005), 32'd0); wait_done();
        send(2'b10, 32'd0, 32'h0000_0200); wait_done();
        send(2'b11, 32'd0, 32'h0000_0800); wait_done();
        send(2'b10, 32'd0, 32'hDEAD_BEEF); wait_done();

        // Reset in the SETTLE cycle of a branch.
        opnd = 32'd0;
        send(2'b01, mk_ir(2'b00, 19'h00003), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (6) @(negedge clk);

        // Valid held high across a busy branch.
        send(2'b01, mk_ir(2'b00, 19'h00003), 32'd0);
        send(2'b00, 32'd0, 32'd0);
        wait_done();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
